// File: rtl/pf_ddr4_rd_train_pkg.sv
// Shared types and constants for the DDR4 per-lane read-training sequencer.
//   state_e : sequencer state encoding
//   ERR_*   : values reported on ERR_CODE
//   TMR_W   : width of the shared settle/sample down-counter
package pf_ddr4_rd_train_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CLEAR,
        ST_SAMPLE,
        ST_EVAL,
        ST_STEP,
        ST_CENTER,
        ST_CWAIT,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_NO_WINDOW = 2'b01;
    localparam logic [1:0] ERR_NARROW    = 2'b10;

    localparam int TMR_W = 16;

endpackage

// File: rtl/pf_ddr4_rd_train_timer.sv
// Loadable down-counter with an expiry flag, shared by every timed wait of
// the training sequencer.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset (counter -> 0)
//   load_i    : load val_i this cycle (takes priority over counting)
//   val_i     : value to load; the wait lasts val_i+1 cycles including expiry
//   expired_o : counter is zero
module pf_ddr4_rd_train_timer
    import pf_ddr4_rd_train_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pf_ddr4_lane_rd_train_ctrl.sv
// Per-lane DDR4 read-training sequencer. Loads the IOD delay line, sweeps it
// up one tap at a time, scores each tap from the ORed eye-monitor flags,
// finds the passing window and walks the tap back down to the window centre.
//   FAB_CLK, SYNC_RST              : clock, synchronous active-high reset
//   TRAIN_START / BUSY / DONE / ERR: training master handshake
//   ERR_CODE, TAP_CENTER, WINDOW_WIDTH : training result
//   DELAY_LINE_*_0                 : IOD dynamic delay line control / limit
//   EYE_MONITOR_*_0                : IOD eye monitor clear / flags
module pf_ddr4_lane_rd_train_ctrl
    import pf_ddr4_rd_train_pkg::*;
#(
    parameter int TAP_W         = 8,
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 64,
    parameter int MIN_WINDOW    = 4
) (
    input  logic             FAB_CLK,
    input  logic             SYNC_RST,
    input  logic             TRAIN_START,
    output logic             TRAIN_BUSY,
    output logic             TRAIN_DONE,
    output logic             TRAIN_ERR,
    output logic [1:0]       ERR_CODE,
    output logic [TAP_W-1:0] TAP_CENTER,
    output logic [TAP_W-1:0] WINDOW_WIDTH,
    output logic             DELAY_LINE_LOAD_0,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0,
    output logic             EYE_MONITOR_CLEAR_FLAGS_0,
    input  logic             EYE_MONITOR_EARLY_0,
    input  logic             EYE_MONITOR_LATE_0
);

    localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(MAX_TAPS - 1);
    localparam logic [TAP_W-1:0] MIN_WIDTH = TAP_W'(MIN_WINDOW);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SAMPLE_LD = TMR_W'(SAMPLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [TAP_W-1:0]   left_q, left_d;
    logic [TAP_W-1:0]   right_q, right_d;
    logic               lvld_q, lvld_d;
    logic               fail_q, fail_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic [TAP_W-1:0]   center_q, center_d;
    logic [TAP_W-1:0]   width_q, width_d;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_exp;

    // Edge update and finish decision for the tap under evaluation.
    logic               ev_finish;
    logic               ev_lvld;
    logic [TAP_W-1:0]   ev_left, ev_right, ev_width;

    pf_ddr4_rd_train_timer #(.W(TMR_W)) u_timer (
        .clk_i     (FAB_CLK),
        .rst_i     (SYNC_RST),
        .load_i    (tmr_load),
        .val_i     (tmr_val),
        .expired_o (tmr_exp)
    );

    always_comb begin
        ev_finish = 1'b0;
        ev_lvld   = lvld_q;
        ev_left   = left_q;
        ev_right  = right_q;
        // Out-of-range discards this tap's result; edges stay as they were.
        if (DELAY_LINE_OUT_OF_RANGE_0) begin
            ev_finish = 1'b1;
        end else begin
            if (!fail_q) begin
                if (!lvld_q) begin
                    ev_lvld = 1'b1;
                    ev_left = tap_q;
                end
                ev_right = tap_q;
            end else if (lvld_q) begin
                ev_finish = 1'b1;
            end
            if (tap_q == LAST_TAP) ev_finish = 1'b1;
        end
        ev_width = ev_right - ev_left + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        left_d   = left_q;
        right_d  = right_q;
        lvld_d   = lvld_q;
        fail_d   = fail_q;
        dir_d    = dir_q;
        done_d   = done_q;
        err_d    = err_q;
        code_d   = code_q;
        center_d = center_q;
        width_d  = width_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (TRAIN_START) begin
                    state_d = ST_LOAD;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    tap_d   = '0;
                    lvld_d  = 1'b0;
                    left_d  = '0;
                    right_d = '0;
                    dir_d   = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d  = ST_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
            end
            ST_SETTLE: begin
                if (tmr_exp) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                fail_d   = 1'b0;
                state_d  = ST_SAMPLE;
                tmr_load = 1'b1;
                tmr_val  = SAMPLE_LD;
            end
            ST_SAMPLE: begin
                // Accumulate over the whole window so short glitches count.
                fail_d = fail_q | EYE_MONITOR_EARLY_0 | EYE_MONITOR_LATE_0;
                if (tmr_exp) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                lvld_d  = ev_lvld;
                left_d  = ev_left;
                right_d = ev_right;
                if (!ev_finish) begin
                    state_d = ST_STEP;
                end else if (!ev_lvld) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    code_d  = ERR_NO_WINDOW;
                    width_d = '0;
                end else if (ev_width < MIN_WIDTH) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    code_d  = ERR_NARROW;
                    width_d = ev_width;
                end else begin
                    // One idle CWAIT cycle lets DIRECTION=0 settle before
                    // the first decrement MOVE.
                    width_d  = ev_width;
                    center_d = ev_left + ((ev_right - ev_left) >> 1);
                    dir_d    = 1'b0;
                    state_d  = ST_CWAIT;
                    tmr_load = 1'b1;
                    tmr_val  = '0;
                end
            end
            ST_STEP: begin
                tap_d    = tap_q + 1'b1;
                state_d  = ST_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
            end
            ST_CWAIT: begin
                if (tmr_exp) begin
                    if (tap_q == center_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CENTER;
                    end
                end
            end
            ST_CENTER: begin
                tap_d    = tap_q - 1'b1;
                state_d  = ST_CWAIT;
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_q  <= ST_IDLE;
            tap_q    <= '0;
            left_q   <= '0;
            right_q  <= '0;
            lvld_q   <= 1'b0;
            fail_q   <= 1'b0;
            dir_q    <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            center_q <= '0;
            width_q  <= '0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            left_q   <= left_d;
            right_q  <= right_d;
            lvld_q   <= lvld_d;
            fail_q   <= fail_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            center_q <= center_d;
            width_q  <= width_d;
        end
    end

    // Strobes decode straight from the state register, so each is a clean
    // single-cycle pulse per state visit.
    assign DELAY_LINE_LOAD_0         = (state_q == ST_LOAD);
    assign DELAY_LINE_MOVE_0         = (state_q == ST_STEP) || (state_q == ST_CENTER);
    assign EYE_MONITOR_CLEAR_FLAGS_0 = (state_q == ST_CLEAR);
    assign DELAY_LINE_DIRECTION_0    = dir_q;
    assign TRAIN_BUSY   = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign TRAIN_DONE   = done_q;
    assign TRAIN_ERR    = err_q;
    assign ERR_CODE     = code_q;
    assign TAP_CENTER   = center_q;
    assign WINDOW_WIDTH = width_q;

endmodule

// File: tb/tb_pf_ddr4_lane_rd_train_ctrl.sv
module tb_pf_ddr4_lane_rd_train_ctrl;

    localparam int TAP_W = 8;
    localparam int MAXT  = 128;
    localparam int SETC  = 4;
    localparam int SMPC  = 8;
    localparam int MINW  = 4;
    localparam int BUDGET = 5000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, err, load, move, dir, clr;
    logic [1:0]       code;
    logic [TAP_W-1:0] center, width;
    logic             oor, early, late;

    always #5 clk = ~clk;

    pf_ddr4_lane_rd_train_ctrl #(
        .TAP_W(TAP_W), .MAX_TAPS(MAXT), .SETTLE_CYCLES(SETC),
        .SAMPLE_CYCLES(SMPC), .MIN_WINDOW(MINW)
    ) dut (
        .FAB_CLK                   (clk),
        .SYNC_RST                  (rst),
        .TRAIN_START               (start),
        .TRAIN_BUSY                (busy),
        .TRAIN_DONE                (done),
        .TRAIN_ERR                 (err),
        .ERR_CODE                  (code),
        .TAP_CENTER                (center),
        .WINDOW_WIDTH              (width),
        .DELAY_LINE_LOAD_0         (load),
        .DELAY_LINE_MOVE_0         (move),
        .DELAY_LINE_DIRECTION_0    (dir),
        .DELAY_LINE_OUT_OF_RANGE_0 (oor),
        .EYE_MONITOR_CLEAR_FLAGS_0 (clr),
        .EYE_MONITOR_EARLY_0       (early),
        .EYE_MONITOR_LATE_0        (late)
    );

    // IOD model: tap position, eye flags and event counters.
    int   eye_l = 1000, eye_r = -1, glitch_tap = -1, oor_tap = -1;
    int   tap_m = 0, smp_cnt = 100;
    int   n_load = 0, n_inc = 0, n_dec = 0, dir_viol = 0;
    logic dir_prev = 1'b1;

    always @(posedge clk) begin
        if (load)      tap_m <= 0;
        else if (move) tap_m <= dir ? tap_m + 1 : tap_m - 1;
        smp_cnt <= clr ? 0 : smp_cnt + 1;
        if (load) n_load <= n_load + 1;
        if (move && dir)  n_inc <= n_inc + 1;
        if (move && !dir) n_dec <= n_dec + 1;
        if (move && dir != dir_prev) dir_viol <= dir_viol + 1;
        dir_prev <= dir;
    end

    always_comb begin
        early = (tap_m < eye_l);
        late  = (tap_m > eye_r) || (tap_m == glitch_tap && smp_cnt == 3);
        oor   = (oor_tap >= 0) && (tap_m >= oor_tap);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, " outs"}, int'({busy, done, err, code, center, width, load, move, clr}), 0);
        chk({name, " dir"}, int'(dir), 1);
    endtask

    typedef struct {
        int l, r, g, oor;
        int done, err, code, center, width, inc, dec;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input string tag);
        int l0, i0, d0, cyc;
        eye_l = v.l; eye_r = v.r; glitch_tap = v.g; oor_tap = v.oor;
        l0 = n_load; i0 = n_inc; d0 = n_dec;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, " load_lat"}, int'(load), 1);
        chk({tag, " busy"}, int'(busy), 1);
        repeat (40) @(negedge clk);
        start = 1'b1;                      // ignored while busy
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!(done || err) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " timeout"}, int'(cyc < BUDGET), 1);
        chk({tag, " done"}, int'(done), v.done);
        chk({tag, " err"}, int'(err), v.err);
        chk({tag, " code"}, int'(code), v.code);
        chk({tag, " width"}, int'(width), v.width);
        if (v.done != 0) begin
            chk({tag, " center"}, int'(center), v.center);
            chk({tag, " iod_tap"}, tap_m, v.center);
        end
        chk({tag, " inc_moves"}, n_inc - i0, v.inc);
        chk({tag, " dec_moves"}, n_dec - d0, v.dec);
        chk({tag, " loads"}, n_load - l0, 1);
        chk({tag, " busy_end"}, int'(busy), 0);
    endtask

    initial begin
        int l0, cyc;
        //          l    r    g    oor  done err code ctr wid inc dec
        vecs[0] = '{20,  40,  -1,  -1,  1,   0,  0,  30, 21, 41, 11};
        vecs[1] = '{10,  11,  -1,  -1,  0,   1,  2,  0,  2,  12, 0};
        vecs[2] = '{1000, -1, -1,  -1,  0,   1,  1,  0,  0,  127, 0};
        vecs[3] = '{100, 127, -1,  110, 1,   0,  0,  104, 10, 110, 6};
        vecs[4] = '{20,  40,  25,  -1,  1,   0,  0,  22, 5,  25, 3};
        vecs[5] = '{10,  13,  -1,  -1,  1,   0,  0,  11, 4,  14, 3};
        vecs[6] = '{0,   5,   -1,  -1,  1,   0,  0,  2,  6,  6,  4};
        vecs[7] = '{124, 200, -1,  -1,  1,   0,  0,  125, 4, 127, 2};

        // Reset state.
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset no load", n_load, 0);
        rst = 1'b0;

        // START together with reset: reset wins.
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        chk("rst+start busy", int'(busy), 0);
        @(negedge clk);
        chk("rst+start loads", n_load, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during SAMPLE at tap 15.
        eye_l = 20; eye_r = 40; glitch_tap = -1; oor_tap = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!(clr && tap_m == 15) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst reach tap15", int'(cyc < BUDGET), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst");
        rst = 1'b0;
        l0 = n_load;
        repeat (5) @(negedge clk);
        chk("midrst tap kept", tap_m, 15);
        chk("midrst no load", n_load - l0, 0);

        // Clean rerun after the abort must match a fresh run.
        run_vec(vecs[0], "rerun");
        chk("dir stable before move", dir_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
